// File: rtl/t00_ssd_scan.sv
// Multiplexed seven-segment scan controller: steps through digits with
// per-slot blanking, digit enables, leading-zero blanking and frame-synced loads.
module t00_ssd_scan #(
  parameter int NUM_DIGITS   = 4,
  parameter int PRESCALE     = 1000,
  parameter int BLANK_CYCLES = 2
) (
  input  logic                    clk,
  input  logic                    nrst,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic                    value_valid,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic                    lz_suppress,
  output logic [3:0]              nibble,
  output logic                    dec_enable,
  output logic [NUM_DIGITS-1:0]   digit_sel,
  output logic                    frame_done
);

  localparam int CW = $clog2(PRESCALE);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam int VW = 4 * NUM_DIGITS;

  logic [CW-1:0]         cnt_q, cnt_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [VW-1:0]         disp_q, disp_d;
  logic [VW-1:0]         pend_q, pend_d;
  logic                  pflag_q, pflag_d;
  logic [NUM_DIGITS-1:0] en_q;
  logic                  lz_q;

  logic cnt_last, idx_last, idx_bad, frame_end;

  assign cnt_last  = (cnt_q == CW'(PRESCALE - 1));
  assign idx_last  = (idx_q == IW'(NUM_DIGITS - 1));
  assign idx_bad   = (int'(idx_q) >= NUM_DIGITS);
  assign frame_end = cnt_last & idx_last;

  always_comb begin
    cnt_d   = cnt_last ? '0 : cnt_q + CW'(1);
    idx_d   = idx_q;
    disp_d  = disp_q;
    pend_d  = pend_q;
    pflag_d = pflag_q;
    if (idx_bad) begin
      idx_d = '0;
    end else if (cnt_last) begin
      idx_d = idx_last ? '0 : idx_q + IW'(1);
    end
    if (frame_end) begin
      if (value_valid) begin
        disp_d  = value;
        pflag_d = 1'b0;
      end else if (pflag_q) begin
        disp_d  = pend_q;
        pflag_d = 1'b0;
      end
    end else if (value_valid) begin
      pend_d  = value;
      pflag_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      cnt_q   <= '0;
      idx_q   <= '0;
      disp_q  <= '0;
      pend_q  <= '0;
      pflag_q <= 1'b0;
      en_q    <= '0;
      lz_q    <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      disp_q  <= disp_d;
      pend_q  <= pend_d;
      pflag_q <= pflag_d;
      en_q    <= digit_en;
      lz_q    <= lz_suppress;
    end
  end

  logic [NUM_DIGITS-1:0] sel_v;
  logic [3:0]            nib_v;
  logic                  dark, zero_up, blank;

  // zero_up accumulates from the top digit down: all nibbles k..top are zero
  always_comb begin
    sel_v   = '0;
    nib_v   = 4'h0;
    dark    = 1'b1;
    zero_up = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      zero_up = zero_up & (disp_q[4*k +: 4] == 4'h0);
      if (int'(idx_q) == k) begin
        sel_v[k] = 1'b1;
        nib_v    = disp_q[4*k +: 4];
        dark     = ~en_q[k] | (lz_q & (k != 0) & zero_up);
      end
    end
  end

  assign blank      = (int'(cnt_q) < BLANK_CYCLES);
  assign digit_sel  = blank ? '0 : sel_v;
  assign dec_enable = ~blank & ~dark;
  assign nibble     = (blank | dark) ? 4'h0 : nib_v;
  assign frame_done = frame_end;

endmodule
